// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared constants and types for the CDB arbiter slice.
//   N_REQ             number of execution-unit result requesters
//   COMMIT_RING_WIDTH width of a commit-ring slot index (CDB tag)
//   DATA_WIDTH        result data width
//   cdb_t             registered broadcast bundle {valid, tag, fpr, data}
//   grant_kind_e      which rule produced this cycle's grant
package cdb_arbiter_pkg;

  localparam int N_REQ             = 4;
  localparam int COMMIT_RING_WIDTH = 4;
  localparam int TAG_WIDTH         = COMMIT_RING_WIDTH;
  localparam int DATA_WIDTH        = 32;
  localparam int PTR_WIDTH         = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic                  valid;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  fpr;
    logic [DATA_WIDTH-1:0] data;
  } cdb_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_AGE  = 2'd1,
    GRANT_RR   = 2'd2
  } grant_kind_e;

  function automatic logic [PTR_WIDTH-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [PTR_WIDTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | PTR_WIDTH'(i);
    end
    return idx;
  endfunction

  // Explicit wrap so non-power-of-two N_REQ still returns to 0.
  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] idx);
    if (int'(idx) == N_REQ - 1) return '0;
    return idx + PTR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: result-request bus from the execution units plus the
// registered CDB broadcast.
//   req_valid/req_ready  per-requester handshake (ready is the grant)
//   req_tag/req_fpr/req_data  result payload per requester
//   commit_tag           commit-ring head pointer
//   cdb_valid/tag/fpr/data  registered broadcast
// Modports: master = execution units / commit ring side, slave = arbiter.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic [N_REQ-1:0]                 req_valid;
  logic [N_REQ-1:0]                 req_ready;
  logic [N_REQ-1:0][TAG_WIDTH-1:0]  req_tag;
  logic [N_REQ-1:0]                 req_fpr;
  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [TAG_WIDTH-1:0]             commit_tag;

  logic                  cdb_valid;
  logic [TAG_WIDTH-1:0]  cdb_tag;
  logic                  cdb_fpr;
  logic [DATA_WIDTH-1:0] cdb_data;

  modport master (
    output req_valid, req_tag, req_fpr, req_data, commit_tag,
    input  req_ready, cdb_valid, cdb_tag, cdb_fpr, cdb_data
  );

  modport slave (
    input  req_valid, req_tag, req_fpr, req_data, commit_tag,
    output req_ready, cdb_valid, cdb_tag, cdb_fpr, cdb_data
  );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// cdb_arbiter_rr_picker: combinational rotate-priority encoder.
//   valid  request vector
//   start  index searched first; search continues start+1, ... mod N_REQ
//   grant  one-hot winner (all zero when nothing is valid)
//   any    at least one request is valid
module cdb_arbiter_rr_picker
  import cdb_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0]     valid,
  input  logic [PTR_WIDTH-1:0] start,
  output logic [N_REQ-1:0]     grant,
  output logic                 any
);

  always_comb begin
    int idx;
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(start) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && valid[idx]) begin
        grant[idx] = 1'b1;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus among the ALU, FPU, load and IN
// result ports. One result per cycle is granted and broadcast on the
// registered cdb_* outputs the following cycle.
//   clk    clock
//   reset  synchronous, active-high; also acts as pipeline flush
//   bus    cdb_arbiter_if.slave (request handshake, commit head, broadcast)
// Grant order: the result whose tag equals the commit-ring head wins
// (lowest index on a tie); otherwise round-robin from rr_ptr.
// Build option: CDB_AGE_PRIO_EN enables the commit-head priority; without it
// the arbiter is pure round-robin and commit_tag is ignored.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  cdb_arbiter_if.slave bus
);

  logic [N_REQ-1:0]     age_hit;
  logic [N_REQ-1:0]     age_grant;
  logic [N_REQ-1:0]     rr_grant;
  logic                 rr_any;
  logic [N_REQ-1:0]     grant;
  logic [PTR_WIDTH-1:0] sel;
  logic [PTR_WIDTH-1:0] rr_ptr;
  logic [PTR_WIDTH-1:0] rr_ptr_nxt;
  grant_kind_e          kind;
  cdb_t                 cdb_q;
  cdb_t                 cdb_d;

`ifdef CDB_AGE_PRIO_EN
  always_comb begin
    age_hit = '0;
    for (int i = 0; i < N_REQ; i++) begin
      age_hit[i] = bus.req_valid[i] && (bus.req_tag[i] == bus.commit_tag);
    end
  end
`else
  logic unused_commit_tag;
  assign unused_commit_tag = ^bus.commit_tag;
  assign age_hit = '0;
`endif

  // Lowest-index commit-head match; tags are unique so at most one is set in
  // legal traffic, but the tie-break keeps the grant one-hot regardless.
  always_comb begin
    logic found;
    age_grant = '0;
    found     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && age_hit[i]) begin
        age_grant[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  cdb_arbiter_rr_picker u_rr_picker (
    .valid (bus.req_valid),
    .start (rr_ptr),
    .grant (rr_grant),
    .any   (rr_any)
  );

  // Grant rule selection. Reset forces no grant so a flush never hands a
  // result to the CDB.
  always_comb begin
    kind = GRANT_NONE;
    if (!reset) begin
      if (|age_hit)    kind = GRANT_AGE;
      else if (rr_any) kind = GRANT_RR;
    end
  end

  always_comb begin
    grant      = '0;
    rr_ptr_nxt = rr_ptr;
    cdb_d      = cdb_q;
    cdb_d.valid = 1'b0;
    case (kind)
      GRANT_AGE: grant = age_grant;
      GRANT_RR: begin
        grant      = rr_grant;
        rr_ptr_nxt = next_ptr(onehot_to_idx(rr_grant));
      end
      default: grant = '0;
    endcase
    sel = onehot_to_idx(grant);
    if (kind != GRANT_NONE) begin
      cdb_d.valid = 1'b1;
      cdb_d.tag   = bus.req_tag[sel];
      cdb_d.fpr   = bus.req_fpr[sel];
      cdb_d.data  = bus.req_data[sel];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      cdb_q  <= '0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
      cdb_q  <= cdb_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.cdb_valid = cdb_q.valid;
  assign bus.cdb_tag   = cdb_q.tag;
  assign bus.cdb_fpr   = cdb_q.fpr;
  assign bus.cdb_data  = cdb_q.data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table-driven bench for cdb_arbiter. Each vector gives the
// request inputs and the expected grant; the expected broadcast is queued
// when the vector is driven and compared after the next clock edge.
// Expectations for the age-priority rows depend on CDB_AGE_PRIO_EN.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  typedef logic [N_REQ-1:0][TAG_WIDTH-1:0]  tags_t;
  typedef logic [N_REQ-1:0][DATA_WIDTH-1:0] data_t;

  typedef struct {
    string                name;
    logic                 rst;
    logic [N_REQ-1:0]     valid;
    tags_t                tags;
    logic [TAG_WIDTH-1:0] commit;
    logic [N_REQ-1:0]     exp_ready;
  } vec_t;

  logic clk;
  logic reset;
  cdb_arbiter_if bus();

  cdb_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  cdb_t sb_q[$];
  cdb_t last_bcast = '0;
  vec_t tbl_a[$];
  vec_t tbl_b[$];

  always @(negedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      for (int j = i + 1; j < N_REQ; j++) begin
        assert (!(bus.req_valid[i] && bus.req_valid[j] && bus.req_tag[i] == bus.req_tag[j]))
          else $error("duplicate request tag %h on requesters %0d and %0d", bus.req_tag[i], i, j);
      end
    end
  end

  function automatic vec_t mk(input string name, input logic rst, input logic [N_REQ-1:0] valid,
                              input tags_t tags, input logic [TAG_WIDTH-1:0] commit,
                              input logic [N_REQ-1:0] exp_ready);
    vec_t v;
    v.name = name; v.rst = rst; v.valid = valid; v.tags = tags;
    v.commit = commit; v.exp_ready = exp_ready;
    return v;
  endfunction

  function automatic data_t default_data(input tags_t tags);
    data_t d;
    for (int i = 0; i < N_REQ; i++)
      d[i] = 32'hA500_0000 + (32'(i) << 16) + 32'(tags[i]);
    return d;
  endfunction

  task automatic run_cycle(input string name, input logic rst, input logic [N_REQ-1:0] valid,
                           input tags_t tags, input data_t data, input logic [TAG_WIDTH-1:0] commit,
                           input logic [N_REQ-1:0] exp_ready);
    cdb_t exp;
    cdb_t got;
    logic [N_REQ-1:0] fpr;
    int gidx;
    for (int i = 0; i < N_REQ; i++) fpr[i] = tags[i][0];
    reset          = rst;
    bus.req_valid  = valid;
    bus.req_tag    = tags;
    bus.req_fpr    = fpr;
    bus.req_data   = data;
    bus.commit_tag = commit;
    #1;
    n_checks++;
    if (bus.req_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL %s ready: got %b expected %b", name, bus.req_ready, exp_ready);
    end
    gidx = -1;
    for (int i = 0; i < N_REQ; i++) if (exp_ready[i]) gidx = i;
    if (rst) begin
      exp = '0;
      last_bcast = '0;
    end else if (gidx >= 0) begin
      exp.valid = 1'b1;
      exp.tag   = tags[gidx];
      exp.fpr   = fpr[gidx];
      exp.data  = data[gidx];
      last_bcast = exp;
    end else begin
      exp = last_bcast;
      exp.valid = 1'b0;
    end
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    got.valid = bus.cdb_valid;
    got.tag   = bus.cdb_tag;
    got.fpr   = bus.cdb_fpr;
    got.data  = bus.cdb_data;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s cdb: scoreboard empty, got v=%b", name, got.valid);
    end else begin
      exp = sb_q.pop_front();
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s cdb: got v=%b tag=%h fpr=%b data=%h expected v=%b tag=%h fpr=%b data=%h",
                 name, got.valid, got.tag, got.fpr, got.data, exp.valid, exp.tag, exp.fpr, exp.data);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    data_t d;
    // Reset, round-robin sweep, idle, and pointer wrap from requester 3.
    tbl_a.push_back(mk("reset0",   1'b1, 4'b1111, 16'h4321, 4'h0, 4'b0000));
    tbl_a.push_back(mk("reset1",   1'b1, 4'b1111, 16'h4321, 4'h0, 4'b0000));
    tbl_a.push_back(mk("rr_g0",    1'b0, 4'b1111, 16'h4321, 4'h0, 4'b0001));
    tbl_a.push_back(mk("rr_g1",    1'b0, 4'b1111, 16'h4321, 4'h0, 4'b0010));
    tbl_a.push_back(mk("rr_g2",    1'b0, 4'b1111, 16'h4321, 4'h0, 4'b0100));
    tbl_a.push_back(mk("rr_g3",    1'b0, 4'b1111, 16'h4321, 4'h0, 4'b1000));
    tbl_a.push_back(mk("rr_g0b",   1'b0, 4'b1111, 16'h4321, 4'h0, 4'b0001));
    tbl_a.push_back(mk("idle",     1'b0, 4'b0000, 16'h4321, 4'h0, 4'b0000));
    tbl_a.push_back(mk("only3",    1'b0, 4'b1000, 16'h4321, 4'h0, 4'b1000));
    tbl_a.push_back(mk("wrap_to0", 1'b0, 4'b1001, 16'h4321, 4'h0, 4'b0001));

    // Tags 5,6,7,9 with commit head 9 on requester 3; rr_ptr is 0 after reset.
`ifdef CDB_AGE_PRIO_EN
    tbl_b.push_back(mk("age_first", 1'b0, 4'b1111, 16'h9765, 4'h9, 4'b1000));
    tbl_b.push_back(mk("age_next",  1'b0, 4'b0111, 16'h9765, 4'h9, 4'b0001));
    tbl_b.push_back(mk("age_rr1",   1'b0, 4'b0110, 16'h9765, 4'h9, 4'b0010));
    tbl_b.push_back(mk("age_rr2",   1'b0, 4'b0100, 16'h9765, 4'h9, 4'b0100));
    tbl_b.push_back(mk("age_hold",  1'b0, 4'b0011, 16'h9765, 4'h5, 4'b0001));
    tbl_b.push_back(mk("age_ptr",   1'b0, 4'b1010, 16'h9765, 4'hF, 4'b1000));
`else
    tbl_b.push_back(mk("noage_first", 1'b0, 4'b1111, 16'h9765, 4'h9, 4'b0001));
    tbl_b.push_back(mk("noage_g1",    1'b0, 4'b1110, 16'h9765, 4'h9, 4'b0010));
    tbl_b.push_back(mk("noage_g2",    1'b0, 4'b1100, 16'h9765, 4'h9, 4'b0100));
    tbl_b.push_back(mk("noage_g3",    1'b0, 4'b1000, 16'h9765, 4'h9, 4'b1000));
    tbl_b.push_back(mk("noage_head",  1'b0, 4'b0011, 16'h9765, 4'h5, 4'b0001));
    tbl_b.push_back(mk("noage_ptr",   1'b0, 4'b1010, 16'h9765, 4'hF, 4'b0010));
`endif

    foreach (tbl_a[k])
      run_cycle(tbl_a[k].name, tbl_a[k].rst, tbl_a[k].valid, tbl_a[k].tags,
                default_data(tbl_a[k].tags), tbl_a[k].commit, tbl_a[k].exp_ready);

    // Reset arriving while requester 2 would be granted: rr_ptr is 3 before
    // the flush, the transfer and the in-flight broadcast are both dropped.
    run_cycle("pre_flush", 1'b0, 4'b0100, 16'h4321, default_data(16'h4321), 4'h0, 4'b0100);
    d = default_data(16'h4321);
    d[2] = 32'hDEADBEEF;
    run_cycle("flush", 1'b1, 4'b0100, 16'h4321, d, 4'h0, 4'b0000);

    foreach (tbl_b[k])
      run_cycle(tbl_b[k].name, tbl_b[k].rst, tbl_b[k].valid, tbl_b[k].tags,
                default_data(tbl_b[k].tags), tbl_b[k].commit, tbl_b[k].exp_ready);

    run_cycle("drain", 1'b0, 4'b0000, 16'h9765, default_data(16'h9765), 4'h0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
